// File: rtl/rs_latch_sequencer.sv
// rtl/rs_latch_sequencer.sv - round-robin arbiter sharing one external RS latch with timed S/R pulses and read-back
module rs_latch_sequencer #(
  parameter int N_REQ     = 4,
  parameter int PULSE_CYC = 3,
  parameter int GAP_CYC   = 2,
  parameter int PTR_W     = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [N_REQ-1:0] SET_REQ,
  input  logic [N_REQ-1:0] CLR_REQ,
  output logic [N_REQ-1:0] GNT,
  output logic             S,
  output logic             R,
  input  logic             Q,
  input  logic             Q_L,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic             STATE_Q
);

  // One counter serves both the pulse and the gap phase; it counts down to zero.
  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic               r_s;
  logic               w_s_nxt;
  logic               r_r;
  logic               w_r_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               r_state_q;
  logic               w_state_q_nxt;
  logic               r_target;
  logic               w_target_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;

  logic [N_REQ-1:0]   w_eligible;
  logic [PTR_W:0]     w_pick;
  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_ptr_after;
  logic               w_readback_ok;

  // Search from ptr upward with wrap; MSB of the result flags that a winner exists.
  function automatic logic [PTR_W:0] pick_winner(input logic [N_REQ-1:0] elig,
                                                 input logic [PTR_W-1:0] ptr);
    logic [PTR_W:0] res;
    int             idx;
    res = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!res[PTR_W] && elig[idx]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  // A requester asking for both set and clear (or neither) is simply not eligible.
  assign w_eligible    = SET_REQ ^ CLR_REQ;
  assign w_pick        = pick_winner(w_eligible, r_ptr);
  assign w_found       = w_pick[PTR_W];
  assign w_winner      = w_pick[PTR_W-1:0];
  assign w_ptr_after   = (w_winner == PTR_LAST) ? '0 : w_winner + 1'b1;
  // Q==Q_L (racing or unpowered latch) never passes, whatever the target.
  assign w_readback_ok = (Q == r_target) && (Q_L == ~r_target);

  // State and all registered outputs; reset drops every drive at once, the latch itself is untouched.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_state_q <= 1'b0;
      r_target  <= 1'b0;
      r_cnt     <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_s       <= w_s_nxt;
      r_r       <= w_r_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_state_q <= w_state_q_nxt;
      r_target  <= w_target_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  // Next-state and next-output logic; S and R are only ever set as complements of one target bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_s_nxt       = 1'b0;
    w_r_nxt       = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_state_q_nxt = r_state_q;
    w_target_nxt  = r_target;
    w_cnt_nxt     = r_cnt;
    w_ptr_nxt     = r_ptr;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
        if (w_found) begin
          w_state_nxt  = ST_PULSE;
          w_gnt_nxt    = N_REQ'(1) << w_winner;
          w_busy_nxt   = 1'b1;
          w_target_nxt = SET_REQ[w_winner];
          w_s_nxt      = SET_REQ[w_winner];
          w_r_nxt      = ~SET_REQ[w_winner];
          w_cnt_nxt    = PULSE_LOAD;
          w_ptr_nxt    = w_ptr_after;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_s_nxt   = r_target;
          w_r_nxt   = ~r_target;
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_CHECK;
          w_done_nxt  = 1'b1;
          if (w_readback_ok) begin
            w_state_q_nxt = r_target;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign GNT     = r_gnt;
  assign S       = r_s;
  assign R       = r_r;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ERR     = r_err;
  assign STATE_Q = r_state_q;

endmodule
